ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the address/PC width.
REQ-002 Parameter BUS_W, default 64, SHALL set the memory data width; legal values are 32, 64 and 128.
REQ-003 Parameter DEPTH, default 4, SHALL set the instruction buffer entry count; it must be a power of two and at least 2.
REQ-004 Parameter RESET_PC, default 64'h0000000080000000, SHALL set the first fetch address.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-low reset.
REQ-007 req_valid  output  1  SHALL indicate a fetch request.
REQ-008 req_ready  input  1  SHALL indicate the memory accepts the request.
REQ-009 req_addr  output  XLEN  SHALL be the fetch PC aligned down to BUS_W/8 bytes.
REQ-010 resp_valid  input  1  SHALL indicate return data for the oldest outstanding request, one cycle wide.
REQ-011 resp_data  input  BUS_W  SHALL carry the returned memory word.
REQ-012 inst_valid  output  1  SHALL indicate the buffer head is valid.
REQ-013 inst_ready  input  1  SHALL indicate the consumer takes the head.
REQ-014 inst  output  32  SHALL be the head instruction.
REQ-015 inst_pc  output  XLEN  SHALL be the head instruction PC.
REQ-016 redirect_valid  input  1  SHALL request a flush and refetch.
REQ-017 redirect_pc  input  XLEN  SHALL be the new fetch PC.
REQ-018 halt  input  1  SHALL inhibit new requests while high.

Function
REQ-019 FSM states SHALL be REQ, WAIT and DROP, with at most one request outstanding.
REQ-020 REQ: req_valid SHALL equal (count < DEPTH) && !halt && !redirect_valid.
REQ-021 REQ: on req_valid && req_ready, the block SHALL latch fetch_pc as pend_pc and go to WAIT.
REQ-022 WAIT: req_valid SHALL be 0.
REQ-023 WAIT: on resp_valid, the block SHALL push {pend_pc, slice} into the buffer, set fetch_pc = pend_pc + 4 and go to REQ.
REQ-024 The slice SHALL be resp_data[32*k +: 32], where k = pend_pc[log2(BUS_W/8)-1:2]; for BUS_W = 32, k = 0.
REQ-025 The buffer SHALL be a registered circular FIFO with wrapping read and write pointers and a count.
REQ-026 inst_valid SHALL be (count != 0); inst and inst_pc SHALL come from the head.
REQ-027 The head SHALL pop when inst_valid && inst_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-028 Latency: a response accepted in cycle N SHALL give inst_valid = 1 in cycle N+1; there is no bypass.
REQ-029 Push never occurs at full, because issue requires count < DEPTH and count cannot rise while in WAIT.
REQ-030 A redirect SHALL flush the buffer: count = 0, pointers = 0, inst_valid = 0 the next cycle, and any same-cycle pop is ignored.
REQ-031 A redirect SHALL set fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
REQ-032 Redirect in REQ SHALL leave the state in REQ, with no request issued that cycle.
REQ-033 Redirect in WAIT without resp_valid SHALL go to DROP.
REQ-034 Redirect in WAIT with resp_valid in the same cycle SHALL discard the response and go to REQ.
REQ-035 Redirect in DROP SHALL update fetch_pc and stay in DROP.
REQ-036 DROP: req_valid SHALL be 0; on resp_valid the data SHALL be discarded and the state SHALL go to REQ.
REQ-037 halt SHALL only block new issue; an outstanding request completes and pushes normally, and the buffer still drains.
REQ-038 resp_valid in REQ SHALL be ignored.

Reset
REQ-039 While rst = 0 the block SHALL set state = REQ, fetch_pc = RESET_PC, pend_pc = 0, count = 0, pointers = 0, req_valid = 0 and inst_valid = 0.
REQ-040 Reset SHALL override any in-flight request; a late response after reset arrives in REQ and is ignored per REQ-038.
REQ-041 The first cycle after release SHALL assert req_valid with req_addr = RESET_PC when halt = 0.

Verification
REQ-042 Reset release, req_ready = 1, response one cycle after each accept with resp_data = 64'hAAAA0002_00100073 -> first inst = 32'h00100073 at inst_pc 80000000, second inst = 32'hAAAA0002 at inst_pc 80000004.
REQ-043 inst_ready = 0, responses always returned -> exactly DEPTH = 4 entries, PCs 80000000..8000000C, then req_valid stays 0; one pop -> req_valid = 1 with req_addr = 80000010.
REQ-044 Redirect to 80000103 in WAIT without a response -> DROP; the next response is discarded; the next req_addr = 80000100; the first pushed inst_pc = 80000100.
REQ-045 Redirect coincident with resp_valid and inst_ready while count = 2 -> count = 0 next cycle, no push, state REQ, req_addr = redirect target.
REQ-046 halt raised during WAIT -> the response is pushed, no further req_valid until halt falls, then fetch resumes at pend_pc + 4.
REQ-047 BUS_W = 128, fetch at 80000008 with resp_data word[2] = 32'h12345678 -> inst = 32'h12345678.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues one aligned fetch at a time, extracts the
// addressed 32-bit instruction from the returned bus word and queues it with its PC.
module ifu_prefetch #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     BUS_W    = 64,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000000080000000)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [XLEN-1:0]  req_addr,
    input  logic             resp_valid,
    input  logic [BUS_W-1:0] resp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  inst_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             halt
);

    localparam int unsigned WORDS = BUS_W / 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  pend_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]      buf_inst [DEPTH];
    logic [XLEN-1:0]  buf_pc   [DEPTH];

    logic             issue;
    logic             push;
    logic             pop;
    logic [31:0]      slice;

    assign req_addr   = fetch_pc & ~XLEN'(BUS_W / 8 - 1);
    assign inst_valid = rst && (count != '0);
    assign inst       = buf_inst[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];
    assign pop        = inst_valid && inst_ready;
    assign issue      = req_valid && req_ready;

    // Word lane within the bus beat comes from the PC bits above the byte offset.
    always_comb begin
        slice = resp_data[31:0];
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (((pend_pc >> 2) & XLEN'(WORDS - 1)) == XLEN'(w)) begin
                slice = resp_data[32*w +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        push       = 1'b0;
        if (rst) begin
            case (state)
                S_REQ: begin
                    req_valid = (count < CNT_W'(DEPTH)) && !halt && !redirect_valid;
                    if (req_valid && req_ready) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        state_next = resp_valid ? S_REQ : S_DROP;
                    end else if (resp_valid) begin
                        push       = 1'b1;
                        state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    // A response arriving with a redirect still retires the stale
                    // request, so nothing is left outstanding to wait for.
                    if (resp_valid) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pend_pc <= fetch_pc;
            end

            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
            end else if (push) begin
                fetch_pc <= pend_pc + XLEN'(4);
            end

            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= slice;
            buf_pc[wr_ptr]   <= pend_pc;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed self-checking bench for ifu_prefetch: default 64-bit bus instance plus
// a 128-bit bus instance for lane selection.
module tb_ifu_prefetch;

    logic         clk;
    logic         rst;

    logic         req_valid, req_ready, resp_valid, inst_valid, inst_ready;
    logic         redirect_valid, halt;
    logic [63:0]  req_addr, inst_pc, redirect_pc, resp_data;
    logic [31:0]  inst;

    logic         w_req_valid, w_req_ready, w_resp_valid, w_inst_valid, w_inst_ready;
    logic         w_redirect_valid, w_halt;
    logic [63:0]  w_req_addr, w_inst_pc, w_redirect_pc;
    logic [127:0] w_resp_data;
    logic [31:0]  w_inst;

    int n_checks;
    int n_pass;

    ifu_prefetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    ifu_prefetch #(
        .BUS_W (128)
    ) u_wide (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (w_req_valid),
        .req_ready      (w_req_ready),
        .req_addr       (w_req_addr),
        .resp_valid     (w_resp_valid),
        .resp_data      (w_resp_data),
        .inst_valid     (w_inst_valid),
        .inst_ready     (w_inst_ready),
        .inst           (w_inst),
        .inst_pc        (w_inst_pc),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .halt           (w_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One request accepted, response returned the following cycle.
    task automatic fetch(input logic [63:0] data);
        req_ready = 1'b1;
        #1;
        chk("issue_valid", {63'd0, req_valid}, 64'd1);
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = data;
        #1;
        chk("wait_no_req", {63'd0, req_valid}, 64'd0);
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic pop_one();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = '0; w_inst_ready = 1'b0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_halt = 1'b0;

        // Reset
        tick();
        tick();
        #1;
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        rst = 1'b1;
        #1;
        chk("rel_req_valid", {63'd0, req_valid}, 64'd1);
        chk("rel_req_addr", req_addr, 64'h80000000);

        // Two sequential fetches from one bus word
        fetch(64'hAAAA0002_00100073);
        #1;
        chk("f1_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("f1_inst", {32'd0, inst}, 64'h00100073);
        chk("f1_pc", inst_pc, 64'h80000000);
        chk("f2_req_addr", req_addr, 64'h80000000);
        fetch(64'hAAAA0002_00100073);
        #1;
        chk("f2_head_kept", {32'd0, inst}, 64'h00100073);
        pop_one();
        #1;
        chk("f2_inst", {32'd0, inst}, 64'hAAAA0002);
        chk("f2_pc", inst_pc, 64'h80000004);
        pop_one();
        #1;
        chk("drained", {63'd0, inst_valid}, 64'd0);

        // Fill to DEPTH with no consumer
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80000000;
        #1;
        chk("redir_req_blocked", {63'd0, req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch({32'h10000000 + 32'(i), 32'h20000000 + 32'(i)});
        end
        req_ready = 1'b1;
        #1;
        chk("full_no_req", {63'd0, req_valid}, 64'd0);
        tick();
        tick();
        #1;
        chk("full_still_no_req", {63'd0, req_valid}, 64'd0);
        chk("full_head_pc", inst_pc, 64'h80000000);
        chk("full_head_inst", {32'd0, inst}, 64'h20000000);
        req_ready = 1'b0;
        pop_one();
        #1;
        chk("pop_req_valid", {63'd0, req_valid}, 64'd1);
        chk("pop_req_addr", req_addr, 64'h80000010);
        chk("pop_head_pc", inst_pc, 64'h80000004);
        chk("pop_head_inst", {32'd0, inst}, 64'h10000001);

        // Redirect while waiting: drop the stale response
        req_ready = 1'b1;
        tick();
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80000103;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("drop_flush", {63'd0, inst_valid}, 64'd0);
        chk("drop_no_req", {63'd0, req_valid}, 64'd0);
        tick();
        resp_valid = 1'b1;
        resp_data  = 64'hDEADBEEF_DEADBEEF;
        tick();
        resp_valid = 1'b0;
        #1;
        chk("drop_discard", {63'd0, inst_valid}, 64'd0);
        chk("drop_req_valid", {63'd0, req_valid}, 64'd1);
        chk("drop_req_addr", req_addr, 64'h80000100);
        fetch(64'hBBBB0001_CCCC0000);
        #1;
        chk("redir_pc", inst_pc, 64'h80000100);
        chk("redir_inst", {32'd0, inst}, 64'hCCCC0000);

        // Redirect coincident with response and pop, count = 2
        fetch(64'hBBBB0001_CCCC0000);
        req_ready = 1'b1;
        tick();
        req_ready      = 1'b0;
        resp_valid     = 1'b1;
        resp_data      = 64'h11111111_22222222;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80000200;
        inst_ready     = 1'b1;
        tick();
        resp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        #1;
        chk("coinc_flush", {63'd0, inst_valid}, 64'd0);
        chk("coinc_req_valid", {63'd0, req_valid}, 64'd1);
        chk("coinc_req_addr", req_addr, 64'h80000200);
        tick();
        #1;
        chk("coinc_no_push", {63'd0, inst_valid}, 64'd0);

        // Halt raised during WAIT
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        halt       = 1'b1;
        resp_valid = 1'b1;
        resp_data  = 64'h55550001_44440000;
        tick();
        resp_valid = 1'b0;
        #1;
        chk("halt_push", {63'd0, inst_valid}, 64'd1);
        chk("halt_inst", {32'd0, inst}, 64'h44440000);
        chk("halt_no_req", {63'd0, req_valid}, 64'd0);
        req_ready = 1'b1;
        tick();
        pop_one();
        #1;
        chk("halt_drain", {63'd0, inst_valid}, 64'd0);
        chk("halt_still_no_req", {63'd0, req_valid}, 64'd0);
        halt = 1'b0;
        #1;
        chk("unhalt_req_addr", req_addr, 64'h80000200);
        fetch(64'h55550001_44440000);
        #1;
        chk("unhalt_pc", inst_pc, 64'h80000204);
        chk("unhalt_inst", {32'd0, inst}, 64'h55550001);

        // Reset during an outstanding request; late response ignored
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, req_valid}, 64'd0);
        chk("mid_rst_inst", {63'd0, inst_valid}, 64'd0);
        tick();
        rst        = 1'b1;
        resp_valid = 1'b1;
        resp_data  = 64'h99999999_88888888;
        #1;
        chk("post_rst_req", {63'd0, req_valid}, 64'd1);
        chk("post_rst_addr", req_addr, 64'h80000000);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("late_resp_ignored", {63'd0, inst_valid}, 64'd0);

        // 128-bit bus: word lane 2
        w_redirect_valid = 1'b1;
        w_redirect_pc    = 64'h80000008;
        tick();
        w_redirect_valid = 1'b0;
        #1;
        chk("wide_req_addr", w_req_addr, 64'h80000000);
        w_req_ready = 1'b1;
        tick();
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b1;
        w_resp_data  = 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA;
        tick();
        w_resp_valid = 1'b0;
        #1;
        chk("wide_inst", {32'd0, w_inst}, 64'h12345678);
        chk("wide_pc", w_inst_pc, 64'h80000008);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
